// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes one ALU result word into consecutive 8-bit UART
// frames (start, 8 data bits LSB first, optional parity, stop) and raises Busy
// for the whole multi-frame transfer.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit per frame
// (PAR_TYP 0 = even, 1 = odd). Without it the frame is 10 bits and PAR_TYP is unused.
module uart_result_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 8,
  parameter int PAR_TYP      = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ODD = (PAR_TYP != 0);
`endif

  // Reject parameter sets the serializer cannot honour.
  if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0 || CLKS_PER_BIT < 2 ||
      PAR_TYP < 0 || PAR_TYP > 1) begin : g_param_check
    $error("uart_result_tx: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_r, state_nxt;
  logic [BAUD_W-1:0]     baud_r, baud_nxt;
  logic [2:0]            bit_r, bit_nxt;
  logic [BYTE_W-1:0]     byte_r, byte_nxt;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt;
  logic                  tx_r, tx_nxt;
  logic                  busy_r, busy_nxt;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_r, par_nxt;
`endif

  assign bit_end = (baud_r == BAUD_LAST);

  // Next-state logic; TX/Busy are derived from the next state so they can be
  // registered and still appear right after the accepting edge.
  always_comb begin
    state_nxt = state_r;
    baud_nxt  = baud_r;
    bit_nxt   = bit_r;
    byte_nxt  = byte_r;
    shreg_nxt = shreg_r;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_r;
`endif
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;

    if (state_r != S_IDLE) begin
      baud_nxt = bit_end ? '0 : baud_r + BAUD_W'(1);
    end

    case (state_r)
      S_IDLE: begin
        baud_nxt = '0;
        if (Data_Valid) begin
          state_nxt = S_START;
          shreg_nxt = P_DATA;
          byte_nxt  = '0;
          bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          // The shift register exposes the next outgoing bit at position 0,
          // carrying on seamlessly into the following byte.
          shreg_nxt = shreg_r >> 1;
`ifdef UART_TX_PARITY_EN
          par_nxt   = par_r ^ shreg_r[0];
`endif
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            bit_nxt = bit_r + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (byte_r == BYTE_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_START;
            byte_nxt  = byte_r + BYTE_W'(1);
`ifdef UART_TX_PARITY_EN
            par_nxt   = 1'b0;
`endif
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_IDLE:   begin tx_nxt = 1'b1; busy_nxt = 1'b0; end
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_nxt = par_nxt ^ PAR_ODD;
`endif
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= S_IDLE;
      baud_r  <= '0;
      bit_r   <= '0;
      byte_r  <= '0;
      shreg_r <= '0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      baud_r  <= baud_nxt;
      bit_r   <= bit_nxt;
      byte_r  <= byte_nxt;
      shreg_r <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_nxt;
`endif
      tx_r    <= tx_nxt;
      busy_r  <= busy_nxt;
    end
  end

  assign TX_OUT = tx_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_uart_result_tx.sv
// Testbench for uart_result_tx: a reference model records every word the
// transmitter should accept; a monitor rebuilds each expected line waveform
// from the word and compares it cycle by cycle with TX_OUT and Busy.
module tb_uart_result_tx;

  localparam int DW     = 16;
  localparam int CPB    = 4;
  localparam int TB_PAR = 0;
  localparam bit TB_ODD = (TB_PAR != 0);
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NB        = DW / 8;
  localparam int FRAME_CYC = NB * FB * CPB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  uart_result_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .PAR_TYP     (TB_PAR)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is taken when Data_Valid is high and the
  // transmitter has had its full Busy window plus one idle cycle since the
  // previous acceptance.
  logic [DW-1:0] exp_q[$];
  longint        cyc = 0;
  longint        next_free = 0;

  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        exp_q.delete();
        next_free = cyc + 1;
      end else if (Data_Valid && cyc >= next_free) begin
        exp_q.push_back(P_DATA);
        next_free = cyc + FRAME_CYC + 1;
      end
      cyc++;
    end
  end

  // Expected line bits for one word: per byte start, 8 data LSB first,
  // optional parity, stop.
  bit exp_bits[$];

  function automatic void build(input logic [DW-1:0] w);
    logic [7:0] by;
    exp_bits.delete();
    for (int i = 0; i < NB; i++) begin
      by = w[8*i +: 8];
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(by[j]);
`ifdef UART_TX_PARITY_EN
      exp_bits.push_back((^by) ^ TB_ODD);
`endif
      exp_bits.push_back(1'b1);
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  bit in_frame = 0;
  bit pend     = 0;
  bit good     = 1;
  int s        = 0;
  int bad_tx   = 0;
  int bad_exp  = 0;

  initial begin
    logic [DW-1:0] w;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check(TX_OUT === 1'b1 && Busy === 1'b0, "reset_out",
              int'({TX_OUT, Busy}), 2);
        in_frame = 0;
        pend     = 0;
      end else begin
        if (pend) begin
          check(TX_OUT === 1'b1 && Busy === 1'b0, "busy_fall",
                int'({TX_OUT, Busy}), 2);
          pend = 0;
        end else if (!in_frame) begin
          if (Busy !== 1'b0) begin
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_busy", int'(Busy), 0);
            end else begin
              w = exp_q.pop_front();
              build(w);
              in_frame = 1;
              s        = 0;
              good     = 1;
            end
          end else begin
            check(TX_OUT === 1'b1, "idle_line", int'(TX_OUT), 1);
          end
        end
        if (in_frame) begin
          if (TX_OUT !== exp_bits[s / CPB] || Busy !== 1'b1) begin
            if (good) begin
              bad_tx  = int'({TX_OUT, Busy});
              bad_exp = int'({exp_bits[s / CPB], 1'b1});
            end
            good = 0;
          end
          s++;
          if (s % CPB == 0) begin
            check(good, "line_bit", bad_tx, bad_exp);
            good = 1;
          end
          if (s == FRAME_CYC) begin
            in_frame = 0;
            pend     = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w);
    @(negedge CLK);
    P_DATA     = w;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    int gap;
    int len;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    // Single word
    send(16'hA55A);
    repeat (FRAME_CYC + 5) @(negedge CLK);

    // Second request while busy is ignored
    send(16'hA55A);
    repeat (28) @(negedge CLK);
    P_DATA     = 16'h1234;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (FRAME_CYC + 5) @(negedge CLK);

    // Back-to-back with Data_Valid held high
    @(negedge CLK);
    P_DATA     = 16'h00FF;
    Data_Valid = 1'b1;
    repeat (5) @(negedge CLK);
    P_DATA = 16'hFF00;
    repeat (FRAME_CYC + 1) @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (FRAME_CYC + 5) @(negedge CLK);

    // Asynchronous reset in the middle of data bit 3 of byte 0
    send(16'hBEEF);
    repeat (17) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    send(16'h0001);
    repeat (FRAME_CYC + 5) @(negedge CLK);

    // Randomized traffic with data churn outside acceptance
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      P_DATA     = DW'($urandom());
      Data_Valid = 1'b1;
      len = $urandom_range(1, 3);
      for (int c = 0; c < len; c++) @(negedge CLK);
      Data_Valid = 1'b0;
      gap = $urandom_range(0, FRAME_CYC + 10);
      for (int c = 0; c < gap; c++) begin
        @(negedge CLK);
        P_DATA = DW'($urandom());
      end
    end

    repeat (2 * FRAME_CYC + 10) @(negedge CLK);
    check(exp_q.size() == 0 && !in_frame, "drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
